// File: rtl/npc_pkg.sv
// Shared definitions for the NPC commit/writeback slice.
// Holds the datapath sizes, the commit FSM states and the named register indices.
package npc_pkg;

  localparam int XLEN = 64;
  localparam int NR_REG = 32;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_A0 = 5'd10;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALT
  } commit_state_e;

  // An ebreak never updates the register file, even when its wen bit is set.
  function automatic logic isRegWrite(input logic wen, input logic [4:0] rd, input logic ebreak);
    return wen && (rd != REG_ZERO) && !ebreak;
  endfunction

endpackage

// File: rtl/commit_wb_stage_if.sv
// Retire handshake between the pipeline and the commit/writeback stage.
// The master side is the upstream pipeline; the slave side is commit_wb_stage.
interface commit_wb_stage_if #(
  parameter int XLEN = npc_pkg::XLEN
);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      in_rd;
  logic            in_wen;
  logic [XLEN-1:0] in_wdata;
  logic            in_ebreak;

  modport master (
    output in_valid,
    output in_pc,
    output in_rd,
    output in_wen,
    output in_wdata,
    output in_ebreak,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_pc,
    input  in_rd,
    input  in_wen,
    input  in_wdata,
    input  in_ebreak,
    output in_ready
  );

endinterface

// File: rtl/gpr_file.sv
// Architectural GPR file: one write port, two combinational read ports with
// optional same-cycle forwarding, and a flat export of every register.
module gpr_file
  import npc_pkg::*;
#(
  parameter int XLEN   = npc_pkg::XLEN,
  parameter int NR_REG = npc_pkg::NR_REG,
  parameter bit BYPASS = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we_i,
  input  logic [4:0]             waddr_i,
  input  logic [XLEN-1:0]        wdata_i,
  input  logic [4:0]             raddr1_i,
  input  logic [4:0]             raddr2_i,
  output logic [XLEN-1:0]        rdata1_o,
  output logic [XLEN-1:0]        rdata2_o,
  output logic [NR_REG*XLEN-1:0] flat_o
);

  logic [XLEN-1:0] rf_q [NR_REG];
  logic [XLEN-1:0] rf_d [NR_REG];

  // x0 is never written, so its storage stays at the reset value of zero.
  always_comb begin
    rf_d = rf_q;
    if (we_i && (waddr_i != REG_ZERO)) begin
      rf_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_REG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    rdata1_o = rf_q[raddr1_i];
    rdata2_o = rf_q[raddr2_i];
    if (raddr1_i == REG_ZERO) begin
      rdata1_o = '0;
    end else if (BYPASS && we_i && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
    end
    if (raddr2_i == REG_ZERO) begin
      rdata2_o = '0;
    end else if (BYPASS && we_i && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
    end
  end

  // The flat view shows stored state only; forwarded data never appears here.
  for (genvar g = 0; g < NR_REG; g++) begin : g_flat
    assign flat_o[g*XLEN +: XLEN] = rf_q[g];
  end

endmodule

// File: rtl/commit_wb_stage.sv
// Final commit/writeback stage: retires one instruction per cycle, owns the GPRs,
// and raises a sticky break flag once an ebreak has drained through.
module commit_wb_stage
  import npc_pkg::*;
#(
  parameter int              XLEN     = npc_pkg::XLEN,
  parameter int              NR_REG   = npc_pkg::NR_REG,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(npc_pkg::RESET_PC),
  parameter bit              BYPASS   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  commit_wb_stage_if.slave       bus,
  input  logic [4:0]             rs1_addr_i,
  input  logic [4:0]             rs2_addr_i,
  output logic [XLEN-1:0]        rs1_data_o,
  output logic [XLEN-1:0]        rs2_data_o,
  output logic [NR_REG*XLEN-1:0] rf_flat_o,
  output logic [XLEN-1:0]        commit_pc_o,
  output logic                   commit_valid_o,
  output logic                   is_break_o,
  output logic [XLEN-1:0]        halt_code_o,
  output logic [63:0]            instret_o,
  output logic [63:0]            cycle_cnt_o
);

  commit_state_e   state_q, state_d;
  logic [XLEN-1:0] commit_pc_q, commit_pc_d;
  logic            commit_valid_q, commit_valid_d;
  logic [63:0]     instret_q, instret_d;
  logic [63:0]     cycle_q, cycle_d;

  logic accept;
  logic regWrite;

  // Input arriving while not ready is simply ignored; nothing is buffered.
  assign bus.in_ready = (state_q == RUN);
  assign accept       = bus.in_valid && (state_q == RUN);
  assign regWrite     = accept && isRegWrite(bus.in_wen, bus.in_rd, bus.in_ebreak);

  gpr_file #(
    .XLEN   (XLEN),
    .NR_REG (NR_REG),
    .BYPASS (BYPASS)
  ) u_gpr_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (regWrite),
    .waddr_i  (bus.in_rd),
    .wdata_i  (bus.in_wdata),
    .raddr1_i (rs1_addr_i),
    .raddr2_i (rs2_addr_i),
    .rdata1_o (rs1_data_o),
    .rdata2_o (rs2_data_o),
    .flat_o   (rf_flat_o)
  );

  // DRAIN exists so the ebreak's own commit is visible for one cycle before halting.
  always_comb begin
    state_d        = state_q;
    commit_pc_d    = commit_pc_q;
    commit_valid_d = 1'b0;
    instret_d      = instret_q;
    cycle_d        = cycle_q;

    if (state_q != HALT) begin
      cycle_d = cycle_q + 64'd1;
    end

    if (accept) begin
      commit_pc_d    = bus.in_pc;
      commit_valid_d = 1'b1;
      instret_d      = instret_q + 64'd1;
    end

    unique case (state_q)
      RUN: begin
        if (accept && bus.in_ebreak) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      commit_pc_q    <= RESET_PC;
      commit_valid_q <= 1'b0;
      instret_q      <= '0;
      cycle_q        <= '0;
    end else begin
      state_q        <= state_d;
      commit_pc_q    <= commit_pc_d;
      commit_valid_q <= commit_valid_d;
      instret_q      <= instret_d;
      cycle_q        <= cycle_d;
    end
  end

  assign commit_pc_o    = commit_pc_q;
  assign commit_valid_o = commit_valid_q;
  assign is_break_o     = (state_q == HALT);
  assign halt_code_o    = rf_flat_o[REG_A0*XLEN +: XLEN];
  assign instret_o      = instret_q;
  assign cycle_cnt_o    = cycle_q;

endmodule

// File: tb/tb_commit_wb_stage.sv
// Randomized scoreboard bench for commit_wb_stage against a register-array
// reference model that tracks commits, halt progress and counters directly.
module tb_commit_wb_stage;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  typedef struct packed {
    logic [63:0]   pc;
    logic [63:0]   instret;
    logic [2047:0] flat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [4:0]    rs1Addr;
  logic [4:0]    rs2Addr;
  logic [63:0]   rs1Data;
  logic [63:0]   rs2Data;
  logic [2047:0] rfFlat;
  logic [63:0]   commitPc;
  logic          commitValid;
  logic          isBreak;
  logic [63:0]   haltCode;
  logic [63:0]   instret;
  logic [63:0]   cycleCnt;

  int tests = 0;
  int fails = 0;

  exp_t expQ[$];

  logic [63:0] refRf [32];
  logic [63:0] refPc;
  logic [63:0] refInstret;
  logic [63:0] refCycles;
  int          brkAge;
  logic [63:0] nextPc;

  int vRun = 0;
  int lastRun = 0;

  always #5 clk = ~clk;

  commit_wb_stage_if #(.XLEN(64)) bus ();

  commit_wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .rs1_addr_i     (rs1Addr),
    .rs2_addr_i     (rs2Addr),
    .rs1_data_o     (rs1Data),
    .rs2_data_o     (rs2Data),
    .rf_flat_o      (rfFlat),
    .commit_pc_o    (commitPc),
    .commit_valid_o (commitValid),
    .is_break_o     (isBreak),
    .halt_code_o    (haltCode),
    .instret_o      (instret),
    .cycle_cnt_o    (cycleCnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2047:0] refFlat();
    logic [2047:0] f;
    for (int i = 0; i < 32; i++) f[i*64 +: 64] = refRf[i];
    return f;
  endfunction

  function automatic logic [63:0] expRead(input logic [4:0] a, input logic wr,
                                           input logic [4:0] rd, input logic [63:0] wd);
    if (a == 5'd0) return 64'd0;
    if (wr && a == rd) return wd;
    return refRf[a];
  endfunction

  // Monitor: every accepted instruction must show up as exactly one commit pulse.
  always @(posedge clk) begin
    exp_t e;
    #1;
    checkOutput("commit_valid", 64'(commitValid), 64'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      if (commitValid) begin
        checkOutput("commit_pc", commitPc, e.pc);
        checkOutput("commit_instret", instret, e.instret);
        for (int i = 0; i < 32; i++) begin
          checkOutput($sformatf("rf_flat_x%0d", i), rfFlat[i*64 +: 64], e.flat[i*64 +: 64]);
        end
      end
    end
    if (commitValid) begin
      vRun++;
    end else begin
      if (vRun > 0) lastRun = vRun;
      vRun = 0;
    end
  end

  task automatic resetModel();
    for (int i = 0; i < 32; i++) refRf[i] = 64'd0;
    refPc = RST_PC;
    refInstret = 64'd0;
    refCycles = 64'd0;
    brkAge = 0;
    expQ.delete();
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic [4:0] rd,
                               input logic wen, input logic [63:0] wd, input logic eb,
                               input logic [4:0] a1, input logic [4:0] a2);
    logic ready;
    logic acc;
    logic wr;
    exp_t e;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_rd     = rd;
    bus.in_wen    = wen;
    bus.in_wdata  = wd;
    bus.in_ebreak = eb;
    rs1Addr = a1;
    rs2Addr = a2;
    ready = (brkAge == 0);
    acc = v && ready;
    wr = acc && wen && !eb && (rd != 5'd0);
    #1;
    checkOutput("in_ready", 64'(bus.in_ready), 64'(ready));
    checkOutput("rs1_data", rs1Data, expRead(a1, wr, rd, wd));
    checkOutput("rs2_data", rs2Data, expRead(a2, wr, rd, wd));
    if (brkAge < 2) refCycles = refCycles + 64'd1;
    if (brkAge == 1) brkAge = 2;
    if (acc) begin
      if (wr) refRf[rd] = wd;
      refPc = pc;
      refInstret = refInstret + 64'd1;
      if (eb) brkAge = 1;
      e.pc = refPc;
      e.instret = refInstret;
      e.flat = refFlat();
      expQ.push_back(e);
    end
    @(negedge clk);
    checkOutput("is_break", 64'(isBreak), 64'(brkAge >= 2));
    checkOutput("commit_pc_hold", commitPc, refPc);
    checkOutput("instret", instret, refInstret);
    checkOutput("cycle_cnt", cycleCnt, refCycles);
    checkOutput("halt_code", haltCode, refRf[10]);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 5'($urandom_range(0, 31)), 5'd10);
  endtask

  task automatic randomCycle(input bit forceValid);
    logic        v;
    logic [4:0]  rd;
    logic [63:0] wd;
    logic [4:0]  a1;
    v  = forceValid ? 1'b1 : ($urandom_range(0, 3) != 0);
    rd = 5'($urandom_range(0, 31));
    wd = {$urandom, $urandom};
    a1 = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31));
    applyStimulus(v, nextPc, rd, 1'($urandom_range(0, 1)), wd, 1'b0, a1,
                  5'($urandom_range(0, 31)));
    if (v) nextPc = nextPc + 64'd4;
  endtask

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic doReset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = 64'd0;
    bus.in_rd     = 5'd0;
    bus.in_wen    = 1'b0;
    bus.in_wdata  = 64'd0;
    bus.in_ebreak = 1'b0;
    rs1Addr = 5'd0;
    rs2Addr = 5'd0;
    resetModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nextPc = RST_PC;
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("%s_x%0d", tag, i), rfFlat[i*64 +: 64], 64'd0);
    end
  endtask

  initial begin
    doReset();
    repeat (5) idleCycle();
    checkOutput("idle_cycle_cnt", cycleCnt, 64'd5);
    checkOutput("idle_commit_pc", commitPc, RST_PC);
    checkOutput("idle_instret", instret, 64'd0);
    checkAllZero("idle_rf");

    applyStimulus(1'b1, 64'h8000_0000, 5'd5, 1'b1, 64'hDEAD_BEEF, 1'b0, 5'd5, 5'd0);
    checkOutput("x5_written", rfFlat[5*64 +: 64], 64'hDEAD_BEEF);
    applyStimulus(1'b1, 64'h8000_0004, 5'd0, 1'b1, 64'h1234, 1'b0, 5'd0, 5'd5);
    checkOutput("x0_dropped", rfFlat[63:0], 64'd0);
    checkOutput("x0_instret", instret, 64'd2);
    nextPc = 64'h8000_0008;

    repeat (200) randomCycle(1'b0);
    idleCycle();
    repeat (10) randomCycle(1'b1);
    idleCycle();
    checkOutput("b2b_run_len", 64'(lastRun), 64'd10);

    applyStimulus(1'b1, nextPc, 5'd10, 1'b1, 64'd42, 1'b0, 5'd10, 5'd3);
    applyStimulus(1'b1, 64'h8000_0010, 5'd3, 1'b1, 64'hBAD0_BAD0, 1'b1, 5'd3, 5'd10);
    repeat (6) applyStimulus(1'b1, 64'h8000_0100, 5'd7, 1'b1, 64'h77, 1'b0, 5'd7, 5'd10);
    checkOutput("halt_code_42", haltCode, 64'd42);
    checkOutput("halt_commit_pc", commitPc, 64'h8000_0010);
    checkOutput("halt_is_break", 64'(isBreak), 64'd1);

    doReset();
    repeat (40) randomCycle(1'b0);
    applyStimulus(1'b1, 64'h8000_0200, 5'd4, 1'b1, 64'h55, 1'b1, 5'd4, 5'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_is_break", 64'(isBreak), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_commit_pc", commitPc, RST_PC);
    checkOutput("rst_instret", instret, 64'd0);
    checkOutput("rst_cycle_cnt", cycleCnt, 64'd0);
    checkOutput("rst_commit_valid", 64'(commitValid), 64'd0);
    checkAllZero("rst_rf");
    doReset();
    repeat (30) randomCycle(1'b0);
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
